// File: rtl/prog_loader.sv
// Serial program loader: length-prefixed byte stream into CPU memory.
// Holds the CPU in reset until a load completes with a good checksum.
module prog_loader #(
    parameter int MEM_WORDS = 65536,
    parameter int TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA,
        WRITE, CHECK, DONE, ERR
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state;
    logic [15:0]    length;
    logic [31:0]    word;
    logic [7:0]     csum;
    logic [1:0]     bcnt;
    logic [TW-1:0]  tcnt;
    logic [15:0]    wc_next;
    logic [31:0]    len_full;
    logic           accept;

    assign accept   = rx_valid && rx_ready;
    assign wc_next  = word_count + 16'd1;
    assign len_full = {16'd0, length[15:8], rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            length     <= '0;
            word       <= '0;
            csum       <= '0;
            bcnt       <= '0;
            tcnt       <= '0;
            word_count <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN_HI;
                        word_count <= '0;
                        csum       <= '0;
                        bcnt       <= '0;
                        tcnt       <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        length[15:8] <= rx_data;
                        state        <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        length[7:0] <= rx_data;
                        if (len_full > MEM_WORDS)
                            state <= ERR;
                        else if (len_full == 32'd0)
                            state <= CHECK;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word <= {word[23:0], rx_data};
                        csum <= csum ^ rx_data;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    word_count <= wc_next;
                    state <= (wc_next == length) ? CHECK : DATA;
                end
                CHECK: begin
                    if (accept)
                        state <= (rx_data == csum) ? DONE : ERR;
                end
            endcase
            // Idle-gap watchdog; only runs while waiting on a byte
            if (rx_ready) begin
                if (accept)
                    tcnt <= '0;
                else if (tcnt == TW'(TIMEOUT - 1))
                    state <= ERR;
                else
                    tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign rx_ready  = state inside {LEN_HI, LEN_LO, DATA, CHECK};
    assign busy      = state inside {LEN_HI, LEN_LO, DATA, WRITE, CHECK};
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign cpu_run   = (state == DONE);
    assign mem_we    = (state == WRITE);
    assign mem_addr  = word_count;
    assign mem_wdata = word;

endmodule
